// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO.
//
// The CPU enqueues bytes with a one-cycle write strobe. A small circular
// FIFO buffers them, and a four-state FSM serialises each byte as
// start(0), 8 data bits LSB first, stop(1). If the FIFO is not empty when
// a stop bit ends, the next frame starts with no idle gap.
//
// Ports:
//   clk       CPU clock; all state changes on the rising edge.
//   rst       asynchronous, active-high reset.
//   wr_en     one-cycle write strobe from the MMIO decode.
//   wr_data   byte to enqueue; sampled when wr_en=1.
//   clr_ovf   one-cycle strobe that clears overflow.
//   tx        serial line, idle high, driven from a flop.
//   busy      high while a frame is on the line.
//   full      FIFO holds FIFO_DEPTH bytes.
//   empty     FIFO holds no bytes.
//   count     FIFO occupancy.
//   overflow  sticky: a write was dropped because the FIFO was full.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr_ovf,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int BC_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q;
    logic [BC_W-1:0]  bc_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             tx_q;
    logic             ovf_q;
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             bc_end_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [7:0]       head_s;

    assign count_s  = wr_ptr_q - rd_ptr_q;
    assign full_s   = (count_s == DEPTH_C);
    assign empty_s  = (count_s == {CNT_W{1'b0}});
    assign bc_end_s = (bc_q == BC_LAST);
    assign head_s   = mem_q[rd_ptr_q[AW-1:0]];

    // Pop/push decisions; a pop on the same edge frees a slot for a write.
    always_comb begin
        pop_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s) pop_s = 1'b1;
                else          pop_s = 1'b0;
            end
            STOP: begin
                if (bc_end_s && !empty_s) pop_s = 1'b1;
                else                      pop_s = 1'b0;
            end
            default: pop_s = 1'b0;
        endcase
        push_s   = wr_en && (!full_s || pop_s);
        drop_s   = wr_en && !push_s;
        wr_ptr_d = push_s ? (wr_ptr_q + CNT_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + CNT_W'(1)) : rd_ptr_q;
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    // Pointers, sticky overflow and the transmit FSM with its registered line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bc_q     <= {BC_W{1'b0}};
            bit_q    <= 3'd0;
            sh_q     <= 8'h00;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= {CNT_W{1'b0}};
            rd_ptr_q <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            // A dropped write outranks a clear on the same edge.
            if (drop_s)       ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
            else              ovf_q <= ovf_q;

            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop_s) begin
                        sh_q    <= head_s;
                        bc_q    <= {BC_W{1'b0}};
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bc_end_s) begin
                        bc_q    <= {BC_W{1'b0}};
                        bit_q   <= 3'd0;
                        state_q <= DATA;
                        tx_q    <= sh_q[0];
                    end else begin
                        bc_q <= bc_q + BC_W'(1);
                    end
                end
                DATA: begin
                    if (bc_end_s) begin
                        bc_q <= {BC_W{1'b0}};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= sh_q[bit_q + 3'd1];
                        end
                    end else begin
                        bc_q <= bc_q + BC_W'(1);
                    end
                end
                STOP: begin
                    if (bc_end_s) begin
                        bc_q <= {BC_W{1'b0}};
                        if (pop_s) begin
                            // Back-to-back: next start bit follows immediately.
                            sh_q    <= head_s;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bc_q <= bc_q + BC_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    bc_q    <= {BC_W{1'b0}};
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_s;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A frame-level model (byte queue plus a cycle offset into the current
// frame) predicts every output each cycle; directed tests add literal
// expectations and a serial decoder checks byte order on the line.
module tb_uart_tx_mmio;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr_ovf = 1'b0;
    logic          tx, busy, full, empty, overflow;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
        .tx(tx), .busy(busy), .full(full), .empty(empty), .count(count),
        .overflow(overflow)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit dropped;
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
        end else begin
            if (m_active) begin
                m_t++;
                if (m_t == 10*CPB) begin
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front();
                        m_t   = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (m_q.size() > 0) begin
                m_cur    = m_q.pop_front();
                m_t      = 0;
                m_active = 1'b1;
            end
            dropped = wr_en && (m_q.size() >= DEPTH);
            if (wr_en && !dropped) m_q.push_back(wr_data);
            if (dropped)      m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    function automatic logic m_tx();
        logic [9:0] fr;
        if (!m_active) return 1'b1;
        fr = {1'b1, m_cur, 1'b0};
        return fr[m_t / CPB];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("tx",       32'(tx),       32'(m_tx()));
        chk("busy",     32'(busy),     32'(m_active));
        chk("count",    32'(count),    32'(m_q.size()));
        chk("full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    end

    // ---------------- serial decoder ----------------
    bit         dec_en = 1'b0;
    logic [7:0] dec_q[$];

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (dec_en && tx == 1'b0) begin
                repeat (CPB + CPB/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = tx;
                    if (i < 7) repeat (CPB) @(negedge clk);
                end
                repeat (CPB) @(negedge clk);
                chk("dec_stop", 32'(tx), 32'd1);
                dec_q.push_back(b);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (busy) n++;
            else if (empty) done = 1'b1;
            if (!done) tick();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_idle: still active after %0d cycles, required idle", budget);
        end
    endtask

    // Write one byte into an idle, empty transmitter and check its frame literally.
    task automatic send_and_check(input logic [7:0] b, input logic [9:0] fr);
        write_byte(b);
        chk("wr_count", 32'(count), 32'd1);
        chk("wr_empty", 32'(empty), 32'd0);
        chk("wr_tx_idle", 32'(tx), 32'd1);
        tick();
        chk("pop_count", 32'(count), 32'd0);
        for (int c = 0; c < 10*CPB; c++) begin
            chk("frame_tx",   32'(tx),     32'(fr[c/CPB]));
            chk("model_tx",   32'(m_tx()), 32'(fr[c/CPB]));
            chk("frame_busy", 32'(busy),   32'd1);
            tick();
        end
        chk("after_busy", 32'(busy), 32'd0);
        chk("after_tx",   32'(tx),   32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_tx",    32'(tx),       32'd1);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_full",  32'(full),     32'd0);
        chk("rst_empty", 32'(empty),    32'd1);
        chk("rst_count", 32'(count),    32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Single byte 0xA5: frame = stop,A5,start
        send_and_check(8'hA5, 10'b1101001010);

        // Back-to-back frames without idle gap
        write_byte(8'h55);
        write_byte(8'h0F);
        wait_idle(300, n);
        chk("b2b_busy_run", 32'(n), 32'd80);

        // Overflow
        for (int i = 0; i < 5; i++) write_byte(8'(8'h10 + i));
        chk("ovf_count4", 32'(count),    32'd4);
        chk("ovf_full",   32'(full),     32'd1);
        chk("ovf_flag0",  32'(overflow), 32'd0);
        write_byte(8'hEE);
        chk("ovf_set",    32'(overflow), 32'd1);
        chk("ovf_count",  32'(count),    32'd4);
        clr_ovf = 1'b1;
        write_byte(8'hEF);
        clr_ovf = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Write while full on the STOP->START pop edge
        for (int w = 0; w < 100 && !(m_active && m_t == 10*CPB-1); w++) tick();
        chk("sync_stop_end", 32'(m_t), 32'(10*CPB-1));
        write_byte(8'hAB);
        chk("simul_count", 32'(count),    32'd4);
        chk("simul_full",  32'(full),     32'd1);
        chk("simul_ovf",   32'(overflow), 32'd0);
        chk("simul_start", 32'(tx),       32'd0);
        wait_idle(400, n);

        // Reset mid-frame during data bit 3 of 0xC3 (bit 3 = 0)
        write_byte(8'hC3);
        write_byte(8'h99);
        repeat (17) tick();
        chk("pre_rst_tx", 32'(tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx",    32'(tx),    32'd1);
        chk("mid_rst_busy",  32'(busy),  32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_and_check(8'h3C, 10'b1001111000);

        // Wrap-around: 3*DEPTH+1 sequential bytes decoded in order
        dec_q.delete();
        dec_en = 1'b1;
        for (int i = 0; i < 3*DEPTH+1; i++) begin
            for (int w = 0; w < 200 && full; w++) tick();
            chk("wrap_not_full", 32'(full), 32'd0);
            write_byte(8'(i));
        end
        wait_idle(2000, n);
        dec_en = 1'b0;
        chk("dec_count", 32'(dec_q.size()), 32'(3*DEPTH+1));
        for (int i = 0; i < dec_q.size() && i < 3*DEPTH+1; i++)
            chk("dec_byte", 32'(dec_q[i]), 32'(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter. It is the transmit-side counterpart to the UART receive path that feeds the program loader.
- The CPU writes bytes through the MMIO decode in the MEM stage.
- Bytes are buffered in a small FIFO and serialised as 8N1 frames on `tx`.
- Status outputs (full/empty/busy/overflow/count) are returned to the MMIO read mux so software can poll before writing.

Parameters:
- CLKS_PER_BIT, 200, cpu_clk cycles per UART bit (23.04 MHz / 115200); legal values are 2 or more.
- FIFO_DEPTH, 16, number of buffered bytes; must be a power of two, 2 or more.
- CNT_W, 5, width of `count`; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  CPU clock (cpu_clk); all state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- wr_en  in  1  One-cycle write strobe from MMIO decode (store to the TX data address).
- wr_data  in  8  Byte to enqueue; sampled when wr_en=1.
- clr_ovf  in  1  One-cycle strobe that clears `overflow`.
- tx  out  1  Serial output, idle high.
- busy  out  1  1 while a frame is on the line (state is not IDLE).
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- count  out  CNT_W  Current FIFO occupancy.
- overflow  out  1  Sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, immediate):
  - tx=1, busy=0, full=0, empty=1, count=0, overflow=0.
  - State=IDLE; read/write pointers=0; baud counter=0; bit index=0.
  - Reset asserted mid-frame aborts the frame, drives tx=1 immediately and discards FIFO contents.
- FIFO:
  - Circular buffer with pointers of width log2(FIFO_DEPTH)+1; the MSB distinguishes full from empty; wrap-around is by natural overflow.
  - count, full and empty are registered or derived from the registered pointers. They update on the edge after the write or pop.
- Write acceptance:
  - Accepted if wr_en=1 and (full=0 or a pop occurs on the same edge).
  - wr_en=1 with full=1 and no pop: byte dropped, overflow<=1.
  - Simultaneous write and pop: count is unchanged.
  - clr_ovf and a dropping write on the same edge: overflow=1 (set wins).
- State machine (baud counter bc runs 0..CLKS_PER_BIT-1; each state lasts CLKS_PER_BIT cycles):
  - IDLE: tx=1. If empty=0, pop the head into shift register sh, set bc=0, go to START; tx=0 from this edge.
  - START: tx=0. When bc=CLKS_PER_BIT-1, set bc=0 and bit=0, go to DATA, tx=sh[0].
  - DATA: tx=sh[bit], LSB first. At the end of each bit, bit increments. After bit 7 ends, go to STOP, tx=1.
  - STOP: tx=1. At bc=CLKS_PER_BIT-1:
    - if empty=0, pop the next byte and go directly to START (no idle gap; back-to-back frames);
    - otherwise go to IDLE.
- Output timing:
  - tx is driven from a register (glitch-free).
  - busy=1 in START, DATA and STOP.
- Latency:
  - A write on edge k into an empty FIFO while IDLE makes empty=0 after edge k.
  - On edge k+1 the byte is popped and tx falls.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- A write during a frame never disturbs the frame in flight.

Test Plan:
- Single byte, CLKS_PER_BIT=4: write 0xA5 at edge k → tx low from edge k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles; busy=1 for exactly 40 cycles; count returns to 0 at edge k+1.
- Back-to-back: write 0x55 then 0x0F on consecutive cycles → two frames with no idle gap (second start bit immediately follows the first stop bit); empty=1 once the second byte is popped.
- Overflow, FIFO_DEPTH=4: write 5 bytes in 5 consecutive cycles while IDLE → first byte popped at cycle 2, so all 5 are accepted. Then hold line busy and write until full=1; one more write → overflow=1 and count stays 4. clr_ovf → overflow=0.
- Simultaneous write and pop with full=1 at the STOP→START edge → write accepted, count stays FIFO_DEPTH, overflow stays 0.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1, busy=0, empty=1, count=0 asynchronously. After release, a new write 0x3C produces a clean full frame.
- Wrap-around: write and transmit 3*FIFO_DEPTH+1 sequential bytes 0x00..0x30 → decoded serial stream matches the order exactly; no loss and no duplication.
